// File: rtl/comparator_pkg.sv
// comparator_pkg: shared result type, signed-mapping helper and default counter width
// for the comparator_stream block.
package comparator_pkg;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_res_t;

    localparam int CNT_W_DEFAULT = 16;

    // Widest operand the core supports; operands are zero-extended to this before comparing.
    localparam int MAX_W = 64;

    // Flipping the sign bit turns two's-complement order into plain unsigned order.
    function automatic logic [MAX_W-1:0] msb_flip(input logic [MAX_W-1:0] v, input int w);
        logic [MAX_W-1:0] m;
        m = MAX_W'(1) << (w - 1);
        return v ^ m;
    endfunction

endpackage

// File: rtl/comparator_stream_if.sv
// comparator_stream_if: operand-pair input stream and one-hot result output stream.
// master = producer/consumer side, slave = the comparator itself.
interface comparator_stream_if #(
    parameter int WIDTH = 8
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_signed;
    logic             out_valid;
    logic             out_ready;
    logic             out_gt;
    logic             out_eq;
    logic             out_lt;

    modport master (
        output in_valid, in_a, in_b, in_signed, out_ready,
        input  in_ready, out_valid, out_gt, out_eq, out_lt
    );

    modport slave (
        input  in_valid, in_a, in_b, in_signed, out_ready,
        output in_ready, out_valid, out_gt, out_eq, out_lt
    );

endinterface

// File: rtl/comparator_core.sv
// comparator_core: combinational WIDTH-bit magnitude compare, signed or unsigned.
// WIDTH must not exceed comparator_pkg::MAX_W.
module comparator_core
    import comparator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output cmp_res_t         res
);

    logic [MAX_W-1:0] ax;
    logic [MAX_W-1:0] bx;

    // Signed compare reuses the unsigned comparator after the sign-bit flip.
    always_comb begin
        ax = MAX_W'(a);
        bx = MAX_W'(b);
        if (is_signed) begin
            ax = msb_flip(ax, WIDTH);
            bx = msb_flip(bx, WIDTH);
        end
        res.gt = (ax > bx);
        res.eq = (ax == bx);
        res.lt = (ax < bx);
    end

endmodule

// File: rtl/comparator_stream.sv
// comparator_stream: two-stage pipelined comparator on valid/ready streams, 2-cycle latency.
// Define COMPARATOR_STREAM_STATS_EN to add saturating gt/eq/lt result counters.
module comparator_stream
    import comparator_pkg::*;
#(
    parameter int WIDTH = 8
`ifdef COMPARATOR_STREAM_STATS_EN
    ,
    parameter int CNT_W = CNT_W_DEFAULT
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    comparator_stream_if.slave bus
`ifdef COMPARATOR_STREAM_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [CNT_W-1:0]  cnt_gt,
    output logic [CNT_W-1:0]  cnt_eq,
    output logic [CNT_W-1:0]  cnt_lt
`endif
);

    logic             init_done;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_signed;
    logic             s2_valid;
    cmp_res_t         s2_res;
    cmp_res_t         core_res;
    logic             s2_load;
    logic             in_ready_int;

    // S2 accepts when empty or draining; S1 may refill in the same cycle it drains into S2.
    assign s2_load      = !s2_valid || bus.out_ready;
    assign in_ready_int = init_done && (!s1_valid || s2_load);
    assign bus.in_ready = in_ready_int;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_signed <= 1'b0;
        end else if (in_ready_int) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_a      <= bus.in_a;
                s1_b      <= bus.in_b;
                s1_signed <= bus.in_signed;
            end
        end
    end

    comparator_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a        (s1_a),
        .b        (s1_b),
        .is_signed(s1_signed),
        .res      (core_res)
    );

    // Flags are stored zeroed for bubbles so the outputs need no gating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_res   <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            s2_res   <= s1_valid ? core_res : '0;
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_gt    = s2_res.gt;
    assign bus.out_eq    = s2_res.eq;
    assign bus.out_lt    = s2_res.lt;

`ifdef COMPARATOR_STREAM_STATS_EN
    logic out_fire;

    assign out_fire = s2_valid && bus.out_ready;

    // Clear beats a coincident increment; each counter sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_gt <= '0;
            cnt_eq <= '0;
            cnt_lt <= '0;
        end else if (stats_clr) begin
            cnt_gt <= '0;
            cnt_eq <= '0;
            cnt_lt <= '0;
        end else if (out_fire) begin
            if (s2_res.gt && (cnt_gt != '1)) begin
                cnt_gt <= cnt_gt + CNT_W'(1);
            end
            if (s2_res.eq && (cnt_eq != '1)) begin
                cnt_eq <= cnt_eq + CNT_W'(1);
            end
            if (s2_res.lt && (cnt_lt != '1)) begin
                cnt_lt <= cnt_lt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: doc/comparator_stream.md
# comparator_stream

Parametrised, pipelined magnitude comparator: the successor to our fixed 3-bit combinational comparator. It accepts operand pairs of WIDTH bits on a valid/ready stream, compares them as signed or unsigned per transaction, and returns one-hot greater/equal/less flags two cycles later on an output stream with backpressure. It sits between datapath producers and threshold/sorting logic, with optional saturating result counters for debug.

## Interface
- WIDTH, 8: operand width in bits, ≥1
- CNT_W, 16: statistics counter width (only with stats compiled in), ≥1
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept a pair this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_signed  in  1  1: two's-complement compare; 0: unsigned
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_gt  out  1  A > B
- out_eq  out  1  A == B
- out_lt  out  1  A < B
- stats_clr  in  1  synchronous clear of counters (stats build only)
- cnt_gt, cnt_eq, cnt_lt  out  CNT_W each  saturating result counts (stats build only)

## Operation
- Handshake: transfer on in_valid & in_ready (input) and out_valid & out_ready (output). in_a/in_b/in_signed sampled only on input transfer.
- Stage 1 (S1): registers in_a, in_b, in_signed, valid bit.
- Stage 2 (S2): registers compare result of S1 operands, valid bit.
- Each stage loads when empty or when its contents move downstream the same cycle; in_ready = !s1_valid | s2_load.
- Compare: unsigned uses WIDTH-bit magnitude; signed inverts MSB of both operands then compares unsigned. WIDTH=1 signed: 1 (−1) < 0.
- Outputs exactly one-hot whenever out_valid=1; flags are 0 whenever out_valid=0.
- Output held stable while out_valid & !out_ready.
- No reordering, no drop, no duplication.

## Timing
- Reset: in_ready=0 during reset; 1 from first clock after deassertion. out_valid, out_gt, out_eq, out_lt=0; all counters=0; S1/S2 valid=0.
- Latency: 2 cycles from input transfer to out_valid with out_ready held high.
- Throughput: 1 pair/cycle with out_ready=1.
- Backpressure: out_ready low → S2 holds; S1 fills; in_ready drops the cycle after S1 fills (in_ready combinational from out_ready allowed). Full occupancy = 2 pairs.
- Simultaneous output transfer and full pipe: in_ready=1 that cycle, no bubble.
- Reset mid-transfer: in-flight pairs discarded, no output produced.

## Configuration
- COMPARATOR_STREAM_STATS_EN defined: cnt_gt/cnt_eq/cnt_lt increment by 1 on each output transfer with the matching flag; saturate at 2^CNT_W−1; stats_clr forces all to 0 and wins over a coincident increment (that result is not counted).
- Undefined: counters, stats_clr and cnt_* ports absent; CNT_W unused.

## Structure
- comparator_pkg: cmp_res_t (packed struct gt/eq/lt), function for the MSB-flip signed mapping, CNT_W default constant.
- Sub-module comparator_core: combinational WIDTH-bit compare (a, b, is_signed → cmp_res_t); instantiated between S1 and S2.

## Test plan
- Unsigned, WIDTH=8, out_ready=1: (0xF0,0x0F), (0x33,0x33), (0x01,0x02) back-to-back → gt, eq, lt on three consecutive cycles, first 2 cycles after first input.
- Signed: (0xF0,0x0F) with in_signed=1 → lt; (0x80,0x7F) → lt; (0xFF,0xFF) → eq; same pairs unsigned → gt, gt, eq.
- Backpressure: stream 5 pairs, out_ready low 4 cycles → in_ready low after 2 accepted; all 5 results appear in order, outputs stable while stalled.
- Reset mid-stream: assert rst_n=0 with 2 pairs in flight → out_valid=0 immediately, no stale result after release.
- Stats (macro defined, CNT_W=2): 5 gt results → cnt_gt=3 (saturated); stats_clr on cycle of an eq transfer → cnt_eq=0.
- WIDTH=1 signed/unsigned exhaustive 4 pairs each → flags match reference model.
